pipelined_mdu: RTL and testbench

// - Iterative RV32M multiply/divide unit for the 5-stage pipelined core. Sits beside the ALU in the Execute stage.
// - Accepts one M-extension op per start pulse. Holds busyE while iterating so the hazard unit stalls F/D/E.
// - Pulses doneE with the WIDTH-bit result. Honours pipeline flushes via killE.

---
 rtl/pipelined_mdu.sv | 157 +++++++++++++++
 tb/tb_pipelined_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mdu.sv
// rtl/pipelined_mdu.sv - iterative RV32M multiply/divide unit; MDU_EARLY_EXIT_EN enables multiply early exit
module pipelined_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             killE,
  input  logic [2:0]       funct3E,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busyE,
  output logic             doneE,
  output logic [WIDTH-1:0] resultE
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_b;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  // Operand decode at launch: signedness, magnitudes and the divide fast-path cases
  logic             w_a_signed, w_b_signed, w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_div_zero, w_div_ovf, w_fast;
  logic [WIDTH-1:0] w_fast_result;

  assign w_a_signed = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
  assign w_b_signed = funct3E[2] ? ~funct3E[0] : ~funct3E[1];
  assign w_sa       = w_a_signed & srcaE[WIDTH-1];
  assign w_sb       = w_b_signed & srcbE[WIDTH-1];
  assign w_mag_a    = w_sa ? -srcaE : srcaE;
  assign w_mag_b    = w_sb ? -srcbE : srcbE;
  assign w_div_zero = funct3E[2] & (srcbE == '0);
  assign w_div_ovf  = funct3E[2] & ~funct3E[0] & (srcaE == {1'b1, {(WIDTH-1){1'b0}}}) & (&srcbE);
  assign w_fast     = w_div_zero | w_div_ovf;
  // Divide by zero: quotient all-ones, remainder = dividend. Overflow: quotient = dividend, remainder 0.
  assign w_fast_result = w_div_zero ? (funct3E[1] ? srcaE : '1)
                                    : (funct3E[1] ? '0 : srcaE);

  // One iteration of either shift-add multiply or restoring divide
  logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH-1:0]   w_rem_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_b_next;

  assign w_mul_acc  = r_b[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_acc  = w_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_acc_next = r_op[2] ? w_div_acc : w_mul_acc;
  assign w_b_next   = r_op[2] ? r_b : (r_b >> 1);

  // Multiply may stop once no multiplier bits remain
  logic w_early;
`ifdef MDU_EARLY_EXIT_EN
  assign w_early = ~r_op[2] & (w_b_next == '0);
`else
  assign w_early = 1'b0;
`endif

  logic w_last;
  assign w_last = (r_cnt == CW'(1)) | w_early;

  // Sign correction of the finished magnitude result
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem, w_calc_result;

  assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo  = r_neg_q ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
  assign w_calc_result = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                                 : ((r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH]);

  // Control FSM and datapath registers; kill aborts everything but keeps the last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (killE) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (startE) begin
            if (w_fast) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_fast_result;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_op    <= funct3E;
              r_neg_q <= w_sa ^ w_sb;
              r_neg_r <= w_sa;
              r_cnt   <= CW'(WIDTH);
              r_acc   <= funct3E[2] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
              r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
              r_b     <= w_mag_b;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_next;
          r_b     <= w_b_next;
          r_mcand <= r_mcand << 1;
          r_cnt   <= r_cnt - CW'(1);
          if (w_last) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_calc_result;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busyE   = r_busy;
  assign doneE   = r_done;
  assign resultE = r_result;

endmodule

// File: tb/tb_pipelined_mdu.sv
// tb/tb_pipelined_mdu.sv - randomized self-checking bench for pipelined_mdu
module tb_pipelined_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startE = 1'b0;
  logic        killE = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        busyE, doneE;
  logic [31:0] resultE;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  pipelined_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .killE(killE), .funct3E(funct3E),
    .srcaE(srcaE), .srcbE(srcbE), .busyE(busyE), .doneE(doneE), .resultE(resultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference result from RV32M arithmetic rules on 64-bit integers
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; q = ua / ub; return q[31:0]; end
      3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default: begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
    endcase
  endfunction

  // Reference latency: cycles from start to doneE
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mb;
    int bl;
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    if (EE && !op[2]) begin
      mb = ((op == 3'd0 || op == 3'd1) && b[31]) ? -b : b;
      bl = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) bl = i + 1;
      return ((bl < 1) ? 1 : bl) + 1;
    end
    return 33;
  endfunction

  // Launch one op at the current cycle and follow it to doneE; returns in the done cycle
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit seen, busy_ok;
    funct3E = op; srcaE = a; srcbE = b; startE = 1'b1;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      startE = 1'b0;
      funct3E = 3'($urandom); srcaE = $urandom; srcbE = $urandom;
      n++;
      if (busyE !== (n < exp_lat)) busy_ok = 0;
      if (doneE === 1'b1) seen = 1;
    end
    check({tag, ".lat"}, n, exp_lat);
    check({tag, ".res"}, resultE, exp_res);
    check({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0] op;
    bit early_done;

    #12;
    check("reset.busy", {31'b0, busyE}, 32'd0);
    check("reset.done", {31'b0, doneE}, 32'd0);
    check("reset.res", resultE, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases; each launch falls in the previous DONE cycle (back-to-back)
    run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, EE ? 3 : 33);
    run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu",     3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, EE ? 3 : 33);
    run_op("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0",   3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_by0",    3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run_op("mul_5_3",    3'd0, 32'd5, 32'd3, 32'd15, EE ? 3 : 33);
    run_op("mul_9_0",    3'd0, 32'd9, 32'd0, 32'd0, EE ? 2 : 33);

    // Kill during a DIV in cycle 10, then MUL 6x7 launched in cycle 11
    @(posedge clk); #1;
    prev = resultE;
    early_done = 0;
    funct3E = 3'd4; srcaE = 32'd1000; srcbE = 32'd3; startE = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      startE = 1'b0;
      if (doneE === 1'b1) early_done = 1;
    end
    killE = 1'b1; startE = 1'b1; funct3E = 3'd0; srcaE = 32'd2; srcbE = 32'd2;
    @(posedge clk); #1;
    killE = 1'b0; startE = 1'b0;
    check("kill.busy", {31'b0, busyE}, 32'd0);
    check("kill.done", {31'b0, doneE | early_done}, 32'd0);
    check("kill.res", resultE, prev);
    run_op("kill.mul_6_7", 3'd0, 32'd6, 32'd7, 32'd42, ref_latency(3'd0, 32'd6, 32'd7));

    // Asynchronous reset in the middle of a multiply
    funct3E = 3'd0; srcaE = 32'd123; srcbE = 32'hFFFF; startE = 1'b1;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst.busy", {31'b0, busyE}, 32'd0);
    check("rst.done", {31'b0, doneE}, 32'd0);
    check("rst.res", resultE, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.idle", {30'b0, busyE, doneE}, 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_result(op, a, b), ref_latency(op, a, b));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
